// File: rtl/fir_pkg.sv
// fir_pkg: shared types and constants for the FIR tap sequencer slice.
//   - fir_state_e : sequencer states (IDLE, MAC, DRAIN, OUT)
//   - OP_ADD/OP_MUL : ALU operation select codes
//   - DEF_DW/DEF_AW : default sample/coefficient and accumulator widths
package fir_pkg;

  localparam int DEF_DW = 16;
  localparam int DEF_AW = 32;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_MUL = 2'b01;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MAC   = 2'd1,
    DRAIN = 2'd2,
    OUT   = 2'd3
  } fir_state_e;

endpackage

// File: rtl/fir_delay_line.sv
// fir_delay_line: NTAPS x DW sample shift register.
// Ports:
//   clk       - rising-edge clock
//   clr_i     - synchronous clear of every tap
//   shift_i   - push din_i into tap 0, every tap moves one deeper
//   din_i     - sample to push
//   rd_idx_i  - tap index to read
//   rd_data_o - value of the selected tap
module fir_delay_line
  import fir_pkg::*;
#(
  parameter int NTAPS = 16,
  parameter int DW    = DEF_DW,
  localparam int IW   = $clog2(NTAPS)
) (
  input  logic          clk,
  input  logic          clr_i,
  input  logic          shift_i,
  input  logic [DW-1:0] din_i,
  input  logic [IW-1:0] rd_idx_i,
  output logic [DW-1:0] rd_data_o
);

  logic [DW-1:0] taps_q [NTAPS];

  // Clear has priority over shift; the oldest tap simply falls off the end.
  always_ff @(posedge clk) begin
    if (clr_i) begin
      for (int i = 0; i < NTAPS; i++) taps_q[i] <= '0;
    end else if (shift_i) begin
      taps_q[0] <= din_i;
      for (int i = 1; i < NTAPS; i++) taps_q[i] <= taps_q[i-1];
    end
  end

  assign rd_data_o = taps_q[rd_idx_i];

endmodule

// File: rtl/fir_tap_sequencer.sv
// fir_tap_sequencer: holds the coefficient bank and the sample delay line,
// accepts one sample per in_valid/in_ready handshake, issues one multiply
// per tap to the external ALU, accumulates the returned products and offers
// the result through out_valid/out_ready.
// Ports:
//   clk, rst                       - clock, synchronous active-high reset
//   coef_we/coef_addr/coef_wdata   - coefficient write port (honoured in IDLE only)
//   in_valid/in_ready/in_sample    - sample input handshake
//   alu_a/alu_b/alu_op_sel         - operands and operation to the ALU
//   alu_result                     - ALU product, ALU_LAT cycles after issue
//   out_valid/out_ready/out_data   - filtered output handshake
// Build option: define FIR_SAT_EN for a saturating accumulator (sticky per
// pass); otherwise the accumulator wraps modulo 2^AW.
module fir_tap_sequencer
  import fir_pkg::*;
#(
  parameter int NTAPS   = 16,
  parameter int DW      = DEF_DW,
  parameter int AW      = DEF_AW,
  parameter int ALU_LAT = 1,
  localparam int IW     = $clog2(NTAPS),
  localparam int LW     = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          coef_we,
  input  logic [IW-1:0] coef_addr,
  input  logic [DW-1:0] coef_wdata,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_sample,
  output logic [DW-1:0] alu_a,
  output logic [DW-1:0] alu_b,
  output logic [1:0]    alu_op_sel,
  input  logic [AW-1:0] alu_result,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [AW-1:0] out_data
);

  fir_state_e    state_q, state_d;
  logic [IW-1:0] tap_q;
  logic [LW-1:0] drain_q;
  logic [ALU_LAT-1:0] issue_q;
  logic [AW-1:0] acc_q, acc_d;
  logic [AW-1:0] sum;
  logic [DW-1:0] coef_q [NTAPS];
  logic [DW-1:0] tap_data;
  logic          accept;
  logic          coef_wr;
  logic          prod_valid;

  assign accept     = (state_q == IDLE) && in_valid;
  // Widened compare so an out-of-range address is rejected for any NTAPS.
  assign coef_wr    = (state_q == IDLE) && coef_we &&
                      ({1'b0, coef_addr} < (IW+1)'(NTAPS));
  assign prod_valid = issue_q[ALU_LAT-1];
  assign sum        = acc_q + alu_result;

  fir_delay_line #(
    .NTAPS (NTAPS),
    .DW    (DW)
  ) u_delay (
    .clk       (clk),
    .clr_i     (rst),
    .shift_i   (accept),
    .din_i     (in_sample),
    .rd_idx_i  (tap_q),
    .rd_data_o (tap_data)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic: MAC walks every tap once, DRAIN waits out the ALU
  // pipeline so the last product lands before OUT is entered.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = MAC;
      MAC:     if (tap_q == IW'(NTAPS-1)) state_d = DRAIN;
      DRAIN:   if (drain_q == LW'(ALU_LAT-1)) state_d = OUT;
      OUT:     if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic: the ALU sees real operands only while MAC is issuing.
  always_comb begin
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    alu_op_sel = OP_ADD;
    alu_a      = '0;
    alu_b      = '0;
    case (state_q)
      IDLE: in_ready = 1'b1;
      MAC: begin
        alu_op_sel = OP_MUL;
        alu_a      = tap_data;
        alu_b      = coef_q[tap_q];
      end
      OUT:  out_valid = 1'b1;
      default: ;
    endcase
  end

  assign out_data = acc_q;

  // Tap and drain counters restart whenever their state is not active.
  always_ff @(posedge clk) begin
    if (rst) begin
      tap_q   <= '0;
      drain_q <= '0;
    end else begin
      tap_q   <= (state_q == MAC)   ? tap_q + 1'b1   : '0;
      drain_q <= (state_q == DRAIN) ? drain_q + 1'b1 : '0;
    end
  end

  // Issue flags follow each multiply through the ALU latency so only real
  // products reach the accumulator.
  always_ff @(posedge clk) begin
    if (rst) begin
      issue_q <= '0;
    end else begin
      issue_q[0] <= (state_q == MAC);
      for (int i = 1; i < ALU_LAT; i++) issue_q[i] <= issue_q[i-1];
    end
  end

  // Coefficient bank; a write in the accept cycle lands before MAC reads it.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NTAPS; i++) coef_q[i] <= '0;
    end else if (coef_wr) begin
      coef_q[coef_addr] <= coef_wdata;
    end
  end

`ifdef FIR_SAT_EN
  logic sat_q, sat_d;

  // Saturating accumulate: once clipped, the value sticks until the next accept.
  always_comb begin
    acc_d = acc_q;
    sat_d = sat_q;
    if (accept) begin
      acc_d = '0;
      sat_d = 1'b0;
    end else if (prod_valid && !sat_q) begin
      if ((acc_q[AW-1] == alu_result[AW-1]) && (sum[AW-1] != acc_q[AW-1])) begin
        acc_d = acc_q[AW-1] ? {1'b1, {(AW-1){1'b0}}} : {1'b0, {(AW-1){1'b1}}};
        sat_d = 1'b1;
      end else begin
        acc_d = sum;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) sat_q <= 1'b0;
    else     sat_q <= sat_d;
  end
`else
  // Wrapping accumulate modulo 2^AW.
  always_comb begin
    acc_d = acc_q;
    if (accept)          acc_d = '0;
    else if (prod_valid) acc_d = sum;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) acc_q <= '0;
    else     acc_q <= acc_d;
  end

endmodule

// File: tb/tb_fir_tap_sequencer.sv
// tb_fir_tap_sequencer: directed, table-driven bench for fir_tap_sequencer
// with a one-cycle multiply/add ALU model attached to the ALU port.
module tb_fir_tap_sequencer;

  localparam int NTAPS = 16;
  localparam longint P = 64'sd1073676289;  // 32767 * 32767

  typedef struct {
    logic [15:0] sample;
    longint      expOut;
    bit          wrOnAccept;
    logic [3:0]  wrAddr;
    logic [15:0] wrData;
    bit          lockWrite;
    int          bpCycles;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        coef_we = 1'b0;
  logic [3:0]  coef_addr = '0;
  logic [15:0] coef_wdata = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_sample = '0;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic [1:0]  alu_op_sel;
  logic [31:0] alu_result = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_data;

  int checks = 0;
  int failures = 0;
  logic [15:0] coefModel [NTAPS];
  vec_t impTab [16];
  vec_t ovfTab [16];

  fir_tap_sequencer #(
    .NTAPS(NTAPS), .DW(16), .AW(32), .ALU_LAT(1)
  ) dut (
    .clk(clk), .rst(rst),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_wdata(coef_wdata),
    .in_valid(in_valid), .in_ready(in_ready), .in_sample(in_sample),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op_sel(alu_op_sel), .alu_result(alu_result),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] aluModel(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
    logic signed [31:0] x;
    logic signed [31:0] y;
    x = signed'(a);
    y = signed'(b);
    return (op == 2'b01) ? x * y : x + y;
  endfunction

  // Single-cycle ALU stand-in.
  always @(posedge clk) alu_result <= aluModel(alu_op_sel, alu_a, alu_b);

  // Watchdog so a stuck design still ends the run.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic vec_t mkVec(input logic [15:0] s, input longint e);
    vec_t v;
    v.sample = s; v.expOut = e; v.wrOnAccept = 1'b0; v.wrAddr = '0;
    v.wrData = '0; v.lockWrite = 1'b0; v.bpCycles = 0;
    return v;
  endfunction

  task automatic stepClk();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, "_in_ready"}, longint'(in_ready), 1);
    checkOutput({tag, "_out_valid"}, longint'(out_valid), 0);
    checkOutput({tag, "_out_data"}, longint'(out_data), 0);
    checkOutput({tag, "_alu_a"}, longint'(alu_a), 0);
    checkOutput({tag, "_alu_b"}, longint'(alu_b), 0);
    checkOutput({tag, "_op_sel"}, longint'(alu_op_sel), 0);
  endtask

  task automatic doReset();
    rst = 1'b1;
    stepClk();
    stepClk();
    rst = 1'b0;
    for (int i = 0; i < NTAPS; i++) coefModel[i] = '0;
  endtask

  task automatic writeCoef(input logic [3:0] addr, input logic [15:0] data);
    coef_we = 1'b1; coef_addr = addr; coef_wdata = data;
    stepClk();
    coef_we = 1'b0;
    coefModel[addr] = data;
  endtask

  // One full pass: accept, MAC/DRAIN checks, latency, result, handshake.
  task automatic applyStimulus(input string name, input vec_t v);
    int cyc;
    logic [31:0] held;
    out_ready = (v.bpCycles == 0);
    checkOutput({name, "_in_ready_idle"}, longint'(in_ready), 1);
    in_valid = 1'b1;
    in_sample = v.sample;
    if (v.wrOnAccept) begin
      coef_we = 1'b1; coef_addr = v.wrAddr; coef_wdata = v.wrData;
      coefModel[v.wrAddr] = v.wrData;
    end
    stepClk();
    in_valid = 1'b0;
    coef_we = 1'b0;
    cyc = 1;
    checkOutput({name, "_mac_op"}, longint'(alu_op_sel), 1);
    checkOutput({name, "_mac_a0"}, longint'(signed'(alu_a)), longint'(signed'(v.sample)));
    checkOutput({name, "_mac_b0"}, longint'(signed'(alu_b)), longint'(signed'(coefModel[0])));
    checkOutput({name, "_in_ready_busy"}, longint'(in_ready), 0);
    while (!out_valid && cyc < 60) begin
      if (v.lockWrite && cyc == 3) begin
        coef_we = 1'b1; coef_addr = 4'd3; coef_wdata = 16'd7;
      end else begin
        coef_we = 1'b0;
      end
      stepClk();
      cyc++;
      if (cyc == 17) begin
        checkOutput({name, "_drain_op"}, longint'(alu_op_sel), 0);
        checkOutput({name, "_drain_a"}, longint'(alu_a), 0);
      end
    end
    coef_we = 1'b0;
    checkOutput({name, "_latency"}, longint'(cyc), 18);
    checkOutput({name, "_out_data"}, longint'(signed'(out_data)), v.expOut);
    if (v.bpCycles > 0) begin
      held = out_data;
      for (int i = 2; i <= v.bpCycles + 1; i++) begin
        stepClk();
        checkOutput($sformatf("%s_bp%0d_valid", name, i), longint'(out_valid), 1);
        checkOutput($sformatf("%s_bp%0d_data", name, i), longint'(out_data), longint'(held));
        checkOutput($sformatf("%s_bp%0d_in_ready", name, i), longint'(in_ready), 0);
      end
      out_ready = 1'b1;
    end
    stepClk();
    checkOutput({name, "_taken_valid"}, longint'(out_valid), 0);
    checkOutput({name, "_taken_in_ready"}, longint'(in_ready), 1);
  endtask

  initial begin
    vec_t v;
    longint acc;
    logic signed [31:0] wrapped;

    // Impulse table: 1 then fifteen zeros with coef[k] = k+1 gives 1..16.
    for (int j = 0; j < 16; j++) begin
      impTab[j] = mkVec((j == 0) ? 16'd1 : 16'd0, longint'(j + 1));
    end
    impTab[1].lockWrite = 1'b1;  // write to coef[3] during MAC must be dropped
    impTab[15].bpCycles = 5;

    // Overflow table: n copies of 32767 against coefficients of 32767.
    for (int j = 0; j < 16; j++) begin
      acc = longint'(j + 1) * P;
`ifdef FIR_SAT_EN
      if (acc > 64'sd2147483647) acc = 64'sd2147483647;
      ovfTab[j] = mkVec(16'd32767, acc);
`else
      wrapped = acc[31:0];
      ovfTab[j] = mkVec(16'd32767, longint'(wrapped));
`endif
    end

    $display("[TB] reset values");
    doReset();
    checkIdleOutputs("reset");

    $display("[TB] all-zero coefficients");
    applyStimulus("zero", mkVec(16'd100, 0));

    $display("[TB] coefficient write together with accept");
    v = mkVec(16'd5, 15);
    v.wrOnAccept = 1'b1; v.wrAddr = 4'd0; v.wrData = 16'd3;
    applyStimulus("simul", v);

    $display("[TB] impulse response, write lockout, back-pressure");
    doReset();
    for (int k = 0; k < NTAPS; k++) writeCoef(4'(k), 16'(k + 1));
    for (int j = 0; j < 16; j++) applyStimulus($sformatf("imp%0d", j), impTab[j]);

    $display("[TB] reset in the middle of MAC");
    in_valid = 1'b1; in_sample = 16'd9;
    stepClk();
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) stepClk();  // now presenting tap 5
    rst = 1'b1;
    stepClk();
    rst = 1'b0;
    for (int i = 0; i < NTAPS; i++) coefModel[i] = '0;
    checkIdleOutputs("midrst");
    applyStimulus("after_rst", mkVec(16'd9, 0));

    $display("[TB] overflow");
    doReset();
    for (int k = 0; k < NTAPS; k++) writeCoef(4'(k), 16'd32767);
    for (int j = 0; j < 16; j++) applyStimulus($sformatf("ovf%0d", j), ovfTab[j]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
